// File: rtl/dna_pkg.sv
// rtl/dna_pkg.sv - Q8.24 constants, saturating arithmetic and recursion state type
package dna_pkg;

    localparam logic [31:0] FP_ONE = 32'h0100_0000;
    localparam logic [31:0] FP_SAT = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Q8.24 multiply: keep product bits [55:24]; anything at or above bit 55
    // would not fit a non-negative 32-bit result, so clamp instead of wrapping.
    function automatic logic [31:0] fp_m(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        prod = {32'b0, x} * {32'b0, y};
        if (|prod[63:55]) begin
            return FP_SAT;
        end
        return 32'(prod >> 24);
    endfunction

    // Non-negative saturating add; operands are already <= FP_SAT.
    function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s > {1'b0, FP_SAT}) begin
            return FP_SAT;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/soft_gamma.sv
// rtl/soft_gamma.sv - IDS branch metric for one transmitted bit
//
// Ports:
//   step   : trellis step j (1-based transmitted position)
//   d_from : drift before the bit, d_to : drift after it (d_to - d_from in -1..+1)
//   b      : hypothesised transmitted bit
//   strand : received sequence, bit i is received symbol i
//   gamma  : Q8.24 branch weight, 0 when the branch is impossible
//
// The bit consumes (d_to - d_from + 1) received symbols starting at
// position p = j - 1 + d_from: none on a deletion, the matching symbol on a
// plain transmission, an arbitrary inserted symbol followed by the matching
// symbol on an insertion.
module soft_gamma import dna_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [31:0]           step,
    input  logic signed [31:0]           d_from,
    input  logic signed [31:0]           d_to,
    input  logic                         b,
    input  logic        [DATA_WIDTH-1:0] strand,
    output logic        [31:0]           gamma
);

    localparam logic [31:0] G_DEL      = 32'h0040_0000;
    localparam logic [31:0] G_MATCH    = 32'h0200_0000;
    localparam logic [31:0] G_MISS     = 32'h0080_0000;
    localparam logic [31:0] G_INS_HIT  = FP_ONE;
    localparam logic [31:0] G_INS_MISS = 32'h0040_0000;

    logic signed [31:0] pos;
    logic signed [31:0] delta;
    logic               bit0;
    logic               bit1;

    always_comb begin
        pos   = step - 32'sd1 + d_from;
        delta = d_to - d_from;
        bit0  = 1'b0;
        bit1  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (pos == i) bit0 = strand[i];
            if (pos + 32'sd1 == i) bit1 = strand[i];
        end
        gamma = '0;
        if (delta == -32'sd1) begin
            gamma = G_DEL;
        end else if (delta == 32'sd0) begin
            if (pos >= 0 && pos < DATA_WIDTH) gamma = (bit0 == b) ? G_MATCH : G_MISS;
        end else if (delta == 32'sd1) begin
            if (pos >= 0 && pos + 32'sd1 < DATA_WIDTH) gamma = (bit1 == b) ? G_INS_HIT : G_INS_MISS;
        end
    end

endmodule

// File: rtl/soft_backward.sv
// rtl/soft_backward.sv - serial backward (beta) recursion step of the IDS BCJR decoder
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle request, sampled only when idle
//   N, t       : transmitted length and step to compute (latched at start)
//   strand     : received sequence (latched at start)
//   beta_in    : beta_{t+1}[s][d], held stable by the caller while busy
//   beta_out   : beta_t[s][d], stable from done until the next start
//   busy       : high during INIT and SWEEP
//   done       : one-cycle pulse when beta_out is complete
module soft_backward import dna_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int n          = 10,
    parameter int a          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           N,
    input  logic [31:0]           t,
    input  logic [DATA_WIDTH-1:0] strand,
    input  logic [31:0]           beta_in  [2*n:0][DATA_WIDTH:-n],
    output logic [31:0]           beta_out [2*n:0][DATA_WIDTH:-n],
    output logic                  busy,
    output logic                  done
);

    localparam int M_MOD = 2 * n + 1;

    state_t                  state;
    logic signed [31:0]      len_q;
    logic signed [31:0]      t_q;
    logic [DATA_WIDTH-1:0]   strand_q;
    logic signed [31:0]      s_q;
    logic signed [31:0]      d_q;

    logic signed [31:0]      step;
    logic signed [31:0]      off;
    logic signed [31:0]      s_tmp;
    logic signed [31:0]      s_off;
    logic [31:0]             sum;

    assign busy = (state == ST_INIT) || (state == ST_SWEEP);
    assign done = (state == ST_FIN);
    assign step = t_q + 32'sd1;

    // Syndrome reached through a b=1 branch; reduce (t+1) first so the
    // wrap needs at most one subtraction and never a negative operand.
    always_comb begin
        off   = step % M_MOD;
        s_tmp = s_q + off;
        s_off = (s_tmp >= M_MOD) ? s_tmp - M_MOD : s_tmp;
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_b
        for (genvar gd = 0; gd < 3; gd++) begin : g_d
            logic signed [31:0] d_to;
            logic signed [31:0] sb;
            logic        [31:0] gamma;
            logic        [31:0] bsel;
            logic        [31:0] term;

            assign d_to = d_q + (gd - 1);
            assign sb   = (gb == 0) ? s_q : s_off;

            soft_gamma #(.DATA_WIDTH(DATA_WIDTH)) u_gamma (
                .step   (step),
                .d_from (d_q),
                .d_to   (d_to),
                .b      (gb[0]),
                .strand (strand_q),
                .gamma  (gamma)
            );

            // A target drift outside the stored range matches no entry,
            // so its beta reads as 0 and the term vanishes.
            always_comb begin
                bsel = '0;
                for (int si = 0; si <= 2 * n; si++) begin
                    for (int di = -n; di <= DATA_WIDTH; di++) begin
                        if (si == sb && di == d_to) bsel = beta_in[si][di];
                    end
                end
            end

            assign term = fp_m(gamma, bsel);
        end
    end

    always_comb begin
        sum = sat_add(g_b[0].g_d[0].term, g_b[0].g_d[1].term);
        sum = sat_add(sum, g_b[0].g_d[2].term);
        sum = sat_add(sum, g_b[1].g_d[0].term);
        sum = sat_add(sum, g_b[1].g_d[1].term);
        sum = sat_add(sum, g_b[1].g_d[2].term);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            t_q      <= '0;
            strand_q <= '0;
            s_q      <= '0;
            d_q      <= '0;
            for (int si = 0; si <= 2 * n; si++) begin
                for (int di = -n; di <= DATA_WIDTH; di++) begin
                    beta_out[si][di] <= '0;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= N;
                        t_q      <= t;
                        strand_q <= strand;
                        state    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    s_q <= '0;
                    d_q <= -t_q;
                    for (int si = 0; si <= 2 * n; si++) begin
                        for (int di = -n; di <= DATA_WIDTH; di++) begin
                            beta_out[si][di] <= '0;
                            // Terminal step: only the codeword-end state carries mass.
                            if (t_q == len_q && si == a && di == n - len_q) beta_out[si][di] <= FP_ONE;
                        end
                    end
                    state <= (t_q == len_q) ? ST_FIN : ST_SWEEP;
                end
                ST_SWEEP: begin
                    // Drifts outside the stored range match no entry: the
                    // cycle is spent but nothing is written.
                    for (int si = 0; si <= 2 * n; si++) begin
                        for (int di = -n; di <= DATA_WIDTH; di++) begin
                            if (si == s_q && di == d_q) beta_out[si][di] <= sum;
                        end
                    end
                    if (d_q == len_q - t_q) begin
                        d_q <= -t_q;
                        if (s_q == 2 * n) state <= ST_FIN;
                        else s_q <= s_q + 32'sd1;
                    end else begin
                        d_q <= d_q + 32'sd1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soft_backward.sv
// tb/tb_soft_backward.sv - self-checking bench for soft_backward
module tb_soft_backward;

    localparam int DW = 8;
    localparam int NN = 2;
    localparam int M  = 2 * NN + 1;
    localparam int A  = 0;
    localparam longint ONE = 64'h0100_0000;
    localparam longint SAT = 64'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] n_in;
    logic [31:0] t_in;
    logic [DW-1:0] strand;
    logic [31:0] beta_in  [2*NN:0][DW:-NN];
    logic [31:0] beta_out [2*NN:0][DW:-NN];
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    soft_backward #(.DATA_WIDTH(DW), .n(NN), .a(A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .N        (n_in),
        .t        (t_in),
        .strand   (strand),
        .beta_in  (beta_in),
        .beta_out (beta_out),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int         kind;     // 0 terminal/random, 1 single source, 2 all SAT, 3 random, 4 zero
        int         nv;
        int         tv;
        logic [7:0] str;
        int         pulse_at; // cycle after start to re-pulse start, 0 = none
        int         exp_lat;  // cycles from start edge to done
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    longint exp_b [0:2*NN][-NN:DW];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural IDS branch weight for transmitted position j.
    function automatic longint g_model(int j, int dfrom, int delta, int b, logic [7:0] str);
        int p;
        p = j - 1 + dfrom;
        if (delta == -1) return 64'h0040_0000;
        if (delta == 0) begin
            if (p < 0 || p > DW - 1) return 0;
            return (int'(str[p]) == b) ? 64'h0200_0000 : 64'h0080_0000;
        end
        if (p < 0 || p + 1 > DW - 1) return 0;
        return (int'(str[p+1]) == b) ? ONE : 64'h0040_0000;
    endfunction

    function automatic longint fpm(longint g, longint x);
        longint p;
        p = g * x;
        if (p >= (64'd1 << 55)) return SAT;
        return p / (64'd1 << 24);
    endfunction

    function automatic longint sadd(longint x, longint y);
        return (x + y > SAT) ? SAT : x + y;
    endfunction

    task automatic clear_model();
        for (int s = 0; s <= 2 * NN; s++)
            for (int d = -NN; d <= DW; d++) exp_b[s][d] = 0;
    endtask

    task automatic build_model(input int nv, input int tv, input logic [7:0] str);
        longint acc;
        int sb, dd;
        clear_model();
        if (tv == nv) begin
            if (NN - nv >= -NN) exp_b[A][NN - nv] = ONE;
        end else begin
            for (int s = 0; s <= 2 * NN; s++) begin
                for (int d = -tv; d <= nv - tv; d++) begin
                    if (d < -NN || d > DW) continue;
                    acc = 0;
                    for (int b = 0; b < 2; b++) begin
                        sb = (b == 1) ? (s + tv + 1) % M : s;
                        for (int dl = -1; dl <= 1; dl++) begin
                            dd = d + dl;
                            if (dd < -NN || dd > DW) continue;
                            acc = sadd(acc, fpm(g_model(tv + 1, d, dl, b, str), longint'(beta_in[sb][dd])));
                        end
                    end
                    exp_b[s][d] = acc;
                end
            end
        end
    endtask

    task automatic cmp_beta(input string name);
        int mm, fs, fd;
        longint fg, fe;
        mm = 0; fs = 0; fd = 0; fg = 0; fe = 0;
        for (int s = 0; s <= 2 * NN; s++)
            for (int d = -NN; d <= DW; d++)
                if (longint'(beta_out[s][d]) != exp_b[s][d]) begin
                    if (mm == 0) begin fs = s; fd = d; fg = longint'(beta_out[s][d]); fe = exp_b[s][d]; end
                    mm++;
                end
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL %s: %0d entries differ, first [%0d][%0d] got %0h expected %0h", name, mm, fs, fd, fg, fe);
        end
    endtask

    task automatic fill_beta(input int kind);
        for (int s = 0; s <= 2 * NN; s++)
            for (int d = -NN; d <= DW; d++) begin
                case (kind)
                    1, 4: beta_in[s][d] = 32'h0;
                    2:    beta_in[s][d] = 32'h7FFF_FFFF;
                    default: beta_in[s][d] = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : ($urandom & 32'h03FF_FFFF);
                endcase
            end
        if (kind == 1) beta_in[3][-1] = 32'h0100_0000;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  cyc;
        bit  got, ok_busy, extra;
        fill_beta(v.kind);
        build_model(v.nv, v.tv, v.str);
        @(negedge clk);
        n_in = 32'(v.nv); t_in = 32'(v.tv); strand = v.str; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; got = 0; ok_busy = 1;
        while (cyc < 200) begin
            if (done) begin got = 1; break; end
            if (!busy) ok_busy = 0;
            start = (v.pulse_at > 0 && cyc == v.pulse_at - 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, longint'(got), 1);
        chk({tag, " latency"}, cyc, v.exp_lat);
        chk({tag, " busy_until_done"}, longint'(ok_busy), 1);
        chk({tag, " busy_at_done"}, longint'(busy), 0);
        cmp_beta({tag, " beta_out"});
        if (v.kind == 1) begin
            extra = 0;
            for (int s = 0; s <= 2 * NN; s++)
                for (int d = -NN; d <= DW; d++)
                    if (s != 3 && s != 4 && beta_out[s][d] != 0) extra = 1;
            chk({tag, " single_source_rows"}, longint'(extra), 0);
        end
        if (v.kind == 2) begin
            extra = 0;
            for (int s = 0; s <= 2 * NN; s++)
                for (int d = -NN; d <= DW; d++)
                    if (beta_out[s][d][31]) extra = 1;
            chk({tag, " no_negative_wrap"}, longint'(extra), 0);
        end
        @(negedge clk);
        chk({tag, " done_one_cycle"}, longint'(done), 0);
        cmp_beta({tag, " beta_hold"});
    endtask

    vec_t tbl[10];
    vec_t rv;
    int   cyc;
    bit   early;

    initial begin
        rst_n = 1'b0; start = 1'b0; n_in = '0; t_in = '0; strand = '0;
        fill_beta(4);
        tbl[0] = '{0, 4, 4, 8'hA5, 0, 2};
        tbl[1] = '{1, 4, 3, 8'h3C, 0, 27};
        tbl[2] = '{2, 4, 2, 8'h5A, 0, 27};
        tbl[3] = '{3, 4, 1, 8'h96, 0, 27};
        tbl[4] = '{3, 4, 1, 8'h96, 5, 27};
        tbl[5] = '{3, 8, 0, 8'hFF, 0, 47};
        tbl[6] = '{3, 1, 0, 8'h01, 0, 12};
        tbl[7] = '{3, 8, 8, 8'h00, 0, 2};
        tbl[8] = '{3, 3, 2, 8'h0F, 0, 22};
        tbl[9] = '{4, 5, 2, 8'hC3, 0, 32};

        repeat (3) @(negedge clk);
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        clear_model();
        cmp_beta("reset beta_out");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rv.kind = 3;
            rv.nv = $urandom_range(1, DW);
            rv.tv = $urandom_range(0, rv.nv);
            rv.str = 8'($urandom);
            rv.pulse_at = 0;
            rv.exp_lat = (rv.tv == rv.nv) ? 2 : 2 + M * (rv.nv + 1);
            run_vec(rv, $sformatf("rand%0d", i));
        end

        // Reset in the middle of a sweep.
        fill_beta(3);
        @(negedge clk);
        n_in = 32'd4; t_in = 32'd1; strand = 8'h69; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; early = 0;
        while (cyc < 9) begin
            if (done) early = 1;
            @(negedge clk);
            cyc++;
        end
        chk("midreset no early done", longint'(early), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset busy", longint'(busy), 0);
        chk("midreset done", longint'(done), 0);
        clear_model();
        cmp_beta("midreset beta_out");
        rst_n = 1'b1;
        run_vec(tbl[3], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
